// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU select codes, FSM state encoding and decode helpers for the accumulator CPU
package cpu_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_NOT = 3'd4;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD_IR = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_MEM     = 3'd5;
  localparam logic [2:0] S_WB      = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    return op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR :
           op == OP_NOT ? ALU_NOT : ALU_ADD;
  endfunction
  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {[OP_LOAD:OP_OR]};
  endfunction
  function automatic logic is_illegal(input logic [3:0] op);
    return op inside {[4'hA:4'hE]};
  endfunction
endpackage

// File: rtl/mem_handshake_timer.sv
// mem_handshake_timer: counts un-acked data memory cycles and pulses timeout on the last allowed one
// ports: clk, rst; active_i = FSM in MEM; ack_i = dm_ack; timeout_o = give up this cycle
module mem_handshake_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ack_i,
  output logic timeout_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  // MEM is never re-entered back to back, so clearing while idle is the clear-on-entry
  always_comb cnt_d = (active_i && !ack_i) ? cnt_q + TO_W'(1) : '0;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign timeout_o = active_i && !ack_i && cnt_q == TO_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch/decode/execute sequencer for the 16-bit accumulator CPU
// inputs: clk, rst, run, opcode (from IR), acc_zero, dm_ack
// outputs: im_rd, loadIR, pc_inc, pc_load, dm_req, dm_we, acc_load, acc_src_sel, alu_op,
//          halted, illegal_op, bus_fault (sticky), state_dbg
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       dm_ack,
  output logic       im_rd,
  output logic       loadIR,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       dm_req,
  output logic       dm_we,
  output logic       acc_load,
  output logic       acc_src_sel,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_fault,
  output logic [2:0] state_dbg
);
  logic [2:0] state_q, state_d;
  logic illegal_q, bus_fault_q, timeout;
  mem_handshake_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk(clk), .rst(rst), .active_i(state_q == S_MEM), .ack_i(dm_ack), .timeout_o(timeout)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:   state_d = S_LOAD_IR;
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE:  state_d = opcode == OP_HALT ? S_HALT : is_mem_op(opcode) ? S_MEM :
                           is_illegal(opcode) ? S_FETCH : S_EXEC;
      S_EXEC:    state_d = S_FETCH;
      S_MEM:     state_d = dm_ack ? (opcode == OP_STORE ? S_FETCH : S_WB) : timeout ? S_HALT : S_MEM;
      S_WB:      state_d = S_FETCH;
      default:   state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      illegal_q   <= 1'b0;
      bus_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_op;
      bus_fault_q <= bus_fault;
    end
  end
  // sticky flags rise combinationally in the cycle the condition is seen
  assign illegal_op  = illegal_q || (state_q == S_DECODE && is_illegal(opcode));
  assign bus_fault   = bus_fault_q || timeout;
  assign im_rd       = state_q == S_FETCH;
  assign loadIR      = state_q == S_LOAD_IR;
  assign pc_inc      = state_q == S_LOAD_IR;
  assign pc_load     = state_q == S_EXEC && (opcode == OP_JMP || (opcode == OP_JZ && acc_zero));
  assign dm_req      = state_q == S_MEM;
  assign dm_we       = state_q == S_MEM && opcode == OP_STORE;
  assign acc_load    = state_q == S_WB || (state_q == S_EXEC && opcode == OP_NOT);
  assign acc_src_sel = state_q == S_WB && opcode == OP_LOAD;
  assign alu_op      = (state_q == S_WB && opcode != OP_LOAD) || (state_q == S_EXEC && opcode == OP_NOT) ?
                       alu_of(opcode) : ALU_ADD;
  assign halted      = state_q == S_HALT;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: per-cycle expected traces built from instruction-level rules, directed then random
module tb_cpu_control_unit;
  localparam int MEM_TIMEOUT = 15;
  logic clk = 0, rst = 1, run = 0, acc_zero = 0, dm_ack = 0;
  logic [3:0] opcode = 0;
  logic im_rd, loadIR, pc_inc, pc_load, dm_req, dm_we, acc_load, acc_src_sel, halted, illegal_op, bus_fault;
  logic [2:0] alu_op, state_dbg;
  typedef struct {
    string name;
    logic rst, run, ack, az;
    logic [3:0] op;
    logic [16:0] exp;
  } vec_t;
  vec_t q[$];
  bit ill, bf, noisy;
  int n_chk, n_fail, code;
  cpu_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .acc_zero(acc_zero), .dm_ack(dm_ack),
    .im_rd(im_rd), .loadIR(loadIR), .pc_inc(pc_inc), .pc_load(pc_load), .dm_req(dm_req),
    .dm_we(dm_we), .acc_load(acc_load), .acc_src_sel(acc_src_sel), .alu_op(alu_op),
    .halted(halted), .illegal_op(illegal_op), .bus_fault(bus_fault), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  function automatic logic nz();
    return noisy ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction
  // strb order: im_rd loadIR pc_inc pc_load dm_req dm_we acc_load acc_src_sel
  task automatic put(input string n, input int st, input logic [3:0] op, input logic az, input logic ack,
                     input logic r, input logic rs, input logic [7:0] strb, input logic [2:0] alu);
    vec_t v;
    v.name = n; v.rst = rs; v.run = r; v.ack = ack; v.az = az; v.op = op;
    v.exp = {strb, alu, st == 7, ill, bf, 3'(st)};
    q.push_back(v);
  endtask
  task automatic start();
    put("idle_wait", 0, 4'h0, 0, nz(), 0, 0, 8'h00, 3'd0);
    put("idle_run", 0, 4'h0, 0, nz(), 1, 0, 8'h00, 3'd0);
  endtask
  // code: 0 next instruction follows, 1 ended in HALT, 2 reset applied mid-MEM
  task automatic instr(input logic [3:0] op, input logic az, input int w, input int rst_at, output int c);
    logic pl, bad;
    bit a;
    c = 0;
    bad = op >= 4'hA && op <= 4'hE;
    put("fetch", 1, op, az, nz(), 0, 0, 8'h80, 3'd0);
    put("load_ir", 2, op, az, nz(), 0, 0, 8'h60, 3'd0);
    if (bad) ill = 1;
    put("decode", 3, op, az, nz(), 0, 0, 8'h00, 3'd0);
    if (op == 4'hF) begin c = 1; return; end
    if (bad) return;
    if (op == 0 || op >= 7) begin
      pl = op == 8 || (op == 9 && az);
      put("exec", 4, op, az, nz(), 0, 0, {3'b0, pl, 2'b0, op == 7, 1'b0}, op == 7 ? 3'd4 : 3'd0);
      return;
    end
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      a = k == w;
      if (k == rst_at) begin
        put("mem_rst", 5, op, az, a, 0, 1, {4'b0, 1'b1, op == 2, 2'b0}, 3'd0);
        ill = 0; bf = 0; c = 2;
        return;
      end
      if (!a && k == MEM_TIMEOUT - 1) bf = 1;
      put("mem", 5, op, az, a, 0, 0, {4'b0, 1'b1, op == 2, 2'b0}, 3'd0);
      if (a) break;
      if (k == MEM_TIMEOUT - 1) begin c = 1; return; end
    end
    if (op != 2) put("wb", 6, op, az, nz(), 0, 0, {6'b0, 1'b1, op == 1}, op == 1 ? 3'd0 : 3'(op - 3));
  endtask
  task automatic recover(input int c);
    if (c == 1) begin
      for (int i = 0; i < 3; i++) put("halt", 7, 4'hF, 0, nz(), 1'($urandom_range(0, 1)), 0, 8'h00, 3'd0);
      put("halt_run", 7, 4'hF, 0, 0, 1, 0, 8'h00, 3'd0);
      put("halt_rst", 7, 4'hF, 0, 0, 1, 1, 8'h00, 3'd0);
      ill = 0; bf = 0;
    end
    if (c != 0) start();
  endtask
  initial begin
    int w, ra;
    logic [16:0] got;
    start();
    instr(4'h0, 0, 0, -1, code); instr(4'h0, 0, 0, -1, code);
    instr(4'h3, 0, 2, -1, code);
    instr(4'h2, 0, 0, -1, code);
    instr(4'h9, 0, 0, -1, code); instr(4'h9, 1, 0, -1, code);
    instr(4'h8, 0, 0, -1, code); instr(4'h7, 1, 0, -1, code);
    instr(4'h1, 0, 1, -1, code); instr(4'h4, 0, 0, -1, code);
    instr(4'h5, 1, 3, -1, code); instr(4'h6, 0, 0, -1, code);
    instr(4'h2, 0, MEM_TIMEOUT - 1, -1, code); instr(4'h1, 0, MEM_TIMEOUT - 2, -1, code);
    instr(4'hB, 0, 0, -1, code); instr(4'h0, 0, 0, -1, code);
    instr(4'hF, 0, 0, -1, code); recover(code);
    instr(4'h1, 0, -1, -1, code); recover(code);
    instr(4'h1, 0, -1, 2, code); recover(code);
    noisy = 1;
    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(0, 5));
      ra = $urandom_range(0, 19) == 0 ? int'($urandom_range(0, 3)) : -1;
      instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), w, ra, code);
      recover(code);
    end
    repeat (2) @(posedge clk);
    foreach (q[i]) begin
      @(negedge clk);
      rst = q[i].rst; run = q[i].run; opcode = q[i].op; acc_zero = q[i].az; dm_ack = q[i].ack;
      #1;
      got = {im_rd, loadIR, pc_inc, pc_load, dm_req, dm_we, acc_load, acc_src_sel, alu_op,
             halted, illegal_op, bus_fault, state_dbg};
      n_chk++;
      if (got !== q[i].exp) begin
        n_fail++;
        $display("FAIL %s vec %0d op=%h: got %b expected %b (strobes,alu,halt,ill,bf,state)",
                 q[i].name, i, q[i].op, got, q[i].exp);
      end
      n_chk++;
      if (pc_inc && pc_load) begin
        n_fail++;
        $display("FAIL pc_excl vec %0d: pc_inc=%b pc_load=%b required not both 1", i, pc_inc, pc_load);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Sequencer for the 16-bit accumulator CPU. It drives the instruction register load (loadIR), program counter, instruction/data memory strobes, accumulator load and ALU select through a fetch/decode/execute FSM. Its inputs are the 4-bit opcode from instruction_register and status from the datapath. The 12-bit address field goes directly from the IR to the PC and data memory, so it does not pass through this block.

Parameters:
MEM_TIMEOUT, 15, max cycles dm_req may wait for dm_ack before a bus fault (1..255)
TO_W, 8, width of the timeout counter

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
run  in  1  start execution; sampled only in IDLE
opcode  in  4  opcode field from instruction_register
acc_zero  in  1  accumulator == 0
dm_ack  in  1  data memory completion, one-cycle pulse or level
im_rd  out  1  instruction memory read strobe
loadIR  out  1  IR load enable
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= IR address
dm_req  out  1  data memory request
dm_we  out  1  data memory write (valid with dm_req)
acc_load  out  1  accumulator load enable
acc_src_sel  out  1  0 = ALU result, 1 = data memory
alu_op  out  3  ALU operation select
halted  out  1  in HALT state
illegal_op  out  1  sticky: undefined opcode decoded
bus_fault  out  1  sticky: dm_ack timeout
state_dbg  out  3  current state encoding

Behaviour:
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT, 8 JMP, 9 JZ, F HALT. A through E are illegal.
- States: IDLE, FETCH, LOAD_IR, DECODE, EXEC, MEM, WB, HALT.
- Outputs are combinational from the current state and the opcode input. The IR holds the opcode stable from the cycle after LOAD_IR.
- Reset: state = IDLE. All strobes are 0, alu_op = 0, halted = 0, illegal_op = 0, bus_fault = 0, timeout counter = 0. rst overrides any state, including MEM with dm_req high, and dm_req drops in the next cycle.
- IDLE: go to FETCH when run = 1, otherwise stay.
- FETCH: im_rd = 1 for one cycle, then go to LOAD_IR.
- LOAD_IR: loadIR = 1 and pc_inc = 1 in the same cycle, then go to DECODE.
- DECODE: no strobes. Next state:
  - LOAD, STORE, ADD, SUB, AND, OR: go to MEM.
  - NOP, NOT, JMP, JZ: go to EXEC.
  - HALT: go to HALT.
  - Illegal: set illegal_op, then go to FETCH (treated as NOP).
- EXEC:
  - NOT: acc_load = 1, acc_src_sel = 0, alu_op = NOT.
  - JMP: pc_load = 1.
  - JZ: pc_load = acc_zero.
  - NOP: no strobe.
  - Then go to FETCH.
- MEM:
  - dm_req = 1 every cycle in MEM. dm_we = 1 only for STORE.
  - The timeout counter increments each MEM cycle without ack and clears on MEM entry.
  - If dm_ack is sampled 1: STORE goes to FETCH; all others go to WB.
  - If the counter reaches MEM_TIMEOUT with no ack: set bus_fault and go to HALT.
  - dm_ack outside MEM is ignored.
- WB:
  - acc_load = 1.
  - LOAD: acc_src_sel = 1.
  - ADD/SUB/AND/OR: acc_src_sel = 0, alu_op = ADD 0, SUB 1, AND 2, OR 3 (NOT 4).
  - Then go to FETCH.
- HALT: halted = 1, all strobes 0, absorbing until rst. run is ignored.
- Latency per instruction, from FETCH to next FETCH:
  - NOP, NOT, JMP, JZ: 4 cycles.
  - STORE: 4 cycles plus wait cycles.
  - LOAD and ALU-memory ops: 5 cycles plus wait cycles.
  - A dm_ack in the first MEM cycle means zero wait.
- pc_inc and pc_load are never high in the same cycle.
- illegal_op and bus_fault clear only on rst.

Decomposition:
- Shared package cpu_pkg holds the opcode constants, alu_op encodings and state encoding (IDLE = 0 … HALT = 7). The datapath ALU and instruction_register benches share the same package.
- One natural sub-module: mem_handshake_timer, which takes the counter, clear-on-entry and timeout compare and outputs a timeout pulse.

Test Plan:
1. Reset then run = 1 with opcode = 0 (NOP): strobe sequence im_rd, loadIR+pc_inc, none, none, repeating every 4 cycles; state_dbg follows 1, 2, 3, 4.
2. opcode = 3 (ADD) with dm_ack after 2 wait cycles: dm_req high for 3 cycles with dm_we = 0, then one cycle of acc_load = 1, acc_src_sel = 0, alu_op = 0; total 7 cycles.
3. opcode = 2 (STORE) with dm_ack in the first MEM cycle: one cycle of dm_req = dm_we = 1, no acc_load, FETCH next.
4. opcode = 9 (JZ) with acc_zero = 0, then 1: pc_load = 0, then pc_load = 1 in EXEC.
5. opcode = B: illegal_op rises at DECODE and stays 1; execution continues. Then opcode = F: halted = 1 and stays with run toggled, until rst clears everything.
6. LOAD with dm_ack never asserted: after MEM_TIMEOUT = 15 cycles, bus_fault = 1 and HALT. A separate run asserts rst mid-MEM: dm_req drops next cycle and the state is IDLE.
